// File: rtl/display_select_sequencer.sv
// Display mux select sequencer: debounced manual stepping or timed auto scan
// with blanking between sources, plus freeze, direct load and wrap pulse.
module display_select_sequencer #(
    parameter int unsigned NUM_SELECTS     = 21,
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned BLANK_CYCLES    = 5_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Step_n,
    input  logic       Auto_Mode,
    input  logic       Freeze,
    input  logic       Load,
    input  logic [4:0] Load_Value,
    output logic [4:0] Display_Select,
    output logic       Display_Enable,
    output logic       Scan_Wrap,
    output logic [1:0] State_Out
);

    localparam int unsigned SEL_W   = 5;
    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1)    ? $clog2(DWELL_CYCLES)    : 1;
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 1)    ? $clog2(BLANK_CYCLES)    : 1;
    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_SELECTS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SHOW   = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    // Pushbutton conditioning
    logic             sync_1;
    logic             sync_2;
    logic             deb_level;
    logic [DEB_W-1:0] deb_cnt;
    logic             step_pulse;

    // Sequencer state
    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_nxt;
    logic               enable;
    logic               wrap;
    logic               wrap_nxt;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_nxt;
    logic [BLANK_W-1:0] blank;
    logic [BLANK_W-1:0] blank_nxt;

    logic [SEL_W-1:0]   adv_sel;
    logic               adv_wrap;
    logic               load_ok;

    // Synchronize the raw button, then require DEBOUNCE_CYCLES of disagreement before flipping
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            deb_level  <= 1'b1;
            deb_cnt    <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync_1     <= Step_n;
            sync_2     <= sync_1;
            step_pulse <= 1'b0;
            if (sync_2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level  <= sync_2;
                deb_cnt    <= '0;
                // Only a press (1 -> 0) produces a step event
                step_pulse <= deb_level;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign adv_wrap = (sel == SEL_LAST);
    assign adv_sel  = adv_wrap ? '0 : sel + SEL_W'(1);
    assign load_ok  = Load && (32'(Load_Value) < NUM_SELECTS);

    // Sequencer state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_MANUAL;
            sel    <= '0;
            enable <= 1'b0;
            wrap   <= 1'b0;
            dwell  <= '0;
            blank  <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            enable <= (state_nxt == ST_BLANK);
            wrap   <= wrap_nxt;
            dwell  <= dwell_nxt;
            blank  <= blank_nxt;
        end
    end

    // Next state: Freeze > Load > auto exit > step > timers
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        wrap_nxt  = 1'b0;
        dwell_nxt = dwell;
        blank_nxt = blank;

        if (Freeze) begin
            state_nxt = state;
        end else if (load_ok) begin
            sel_nxt = Load_Value;
            if (state != ST_MANUAL) begin
                state_nxt = ST_SHOW;
                dwell_nxt = '0;
            end
        end else if ((state != ST_MANUAL) && !Auto_Mode) begin
            state_nxt = ST_MANUAL;
        end else begin
            case (state)
                ST_MANUAL: begin
                    if (step_pulse) begin
                        sel_nxt  = adv_sel;
                        wrap_nxt = adv_wrap;
                    end
                    if (Auto_Mode) begin
                        state_nxt = ST_SHOW;
                        dwell_nxt = '0;
                    end
                end
                ST_SHOW: begin
                    if (step_pulse) begin
                        sel_nxt   = adv_sel;
                        wrap_nxt  = adv_wrap;
                        dwell_nxt = '0;
                    end else if (dwell == DWELL_LAST) begin
                        state_nxt = ST_BLANK;
                        blank_nxt = '0;
                    end else begin
                        dwell_nxt = dwell + DWELL_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (blank == BLANK_LAST) begin
                        sel_nxt   = adv_sel;
                        wrap_nxt  = adv_wrap;
                        state_nxt = ST_SHOW;
                        dwell_nxt = '0;
                    end else begin
                        blank_nxt = blank + BLANK_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_MANUAL;
                end
            endcase
        end
    end

    assign Display_Select = sel;
    assign Display_Enable = enable;
    assign Scan_Wrap      = wrap;
    assign State_Out      = state;

endmodule

// File: tb/tb_display_select_sequencer.sv
// Bench for display_select_sequencer: phase-based reference model compared every
// cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_display_select_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned BL = 2;
    localparam int unsigned DB = 3;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Step_n;
    logic       Auto_Mode;
    logic       Freeze;
    logic       Load;
    logic [4:0] Load_Value;
    logic [4:0] Display_Select;
    logic       Display_Enable;
    logic       Scan_Wrap;
    logic [1:0] State_Out;

    always #5 Clock = ~Clock;

    display_select_sequencer #(
        .NUM_SELECTS    (N),
        .DWELL_CYCLES   (DW),
        .BLANK_CYCLES   (BL),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Step_n        (Step_n),
        .Auto_Mode     (Auto_Mode),
        .Freeze        (Freeze),
        .Load          (Load),
        .Load_Value    (Load_Value),
        .Display_Select(Display_Select),
        .Display_Enable(Display_Enable),
        .Scan_Wrap     (Scan_Wrap),
        .State_Out     (State_Out)
    );

    // Reference model: manual flag plus one phase count through show+blank
    bit          m_manual;
    int unsigned m_phase;
    int unsigned m_sel;
    bit          m_wrap;
    bit          m_lvl;
    bit          m_ev;
    bit          samp[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mdl_on = 1'b0;
    bit  lit_on = 1'b0;
    bit [4:0]    lit_mask;
    int unsigned lit_sel, lit_en, lit_st, lit_wrap, lit_wc;
    int unsigned wcount = 0;
    int unsigned hold = 0;

    task automatic model_reset();
        m_manual = 1'b1;
        m_phase  = 0;
        m_sel    = 0;
        m_wrap   = 1'b0;
        m_lvl    = 1'b1;
        m_ev     = 1'b0;
        samp.delete();
        for (int i = 0; i < DB + 2; i++) samp.push_back(1'b1);
    endtask

    task automatic model_adv();
        if (m_sel == N - 1) begin
            m_sel  = 0;
            m_wrap = 1'b1;
        end else begin
            m_sel++;
        end
    endtask

    task automatic model_step();
        bit ev;
        bit diff;
        ev = m_ev;
        samp.push_front(Step_n);
        void'(samp.pop_back());
        // Level flips once the last DB synchronized samples all disagree with it
        diff = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (samp[i] == m_lvl) diff = 1'b0;
        m_ev = diff && m_lvl;
        if (diff) m_lvl = !m_lvl;
        m_wrap = 1'b0;
        if (Freeze) begin
            m_wrap = 1'b0;
        end else if (Load && (Load_Value < N)) begin
            m_sel = Load_Value;
            if (!m_manual) m_phase = 0;
        end else if (!m_manual && !Auto_Mode) begin
            m_manual = 1'b1;
        end else if (m_manual) begin
            if (ev) model_adv();
            if (Auto_Mode) begin
                m_manual = 1'b0;
                m_phase  = 0;
            end
        end else if (m_phase < DW) begin
            if (ev) begin
                model_adv();
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end else if (m_phase == DW + BL - 1) begin
            model_adv();
            m_phase = 0;
        end else begin
            m_phase++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process on the falling edge
    initial begin
        forever begin
            @(negedge Clock);
            if (mdl_on) begin
                check("select", Display_Select, m_sel);
                check("enable", Display_Enable, 32'(!m_manual && (m_phase >= DW)));
                check("state", State_Out, m_manual ? 0 : ((m_phase < DW) ? 1 : 2));
                check("wrap", Scan_Wrap, m_wrap);
            end
            if (lit_on) begin
                if (lit_mask[0]) begin
                    check("lit_select", Display_Select, lit_sel);
                    check("model_select", m_sel, lit_sel);
                end
                if (lit_mask[1]) check("lit_enable", Display_Enable, lit_en);
                if (lit_mask[2]) check("lit_state", State_Out, lit_st);
                if (lit_mask[3]) check("lit_wrap", Scan_Wrap, lit_wrap);
                if (lit_mask[4]) check("lit_wrap_count", wcount, lit_wc);
            end
        end
    end

    task automatic cycle();
        @(posedge Clock);
        lit_on = 1'b0;
        if (Reset_n) model_step();
        else model_reset();
        #2;
        if (Scan_Wrap) wcount++;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic expect_lit(input bit [4:0] mask, input int unsigned s, input int unsigned e,
                              input int unsigned st, input int unsigned w);
        lit_mask = mask;
        lit_sel  = s;
        lit_en   = e;
        lit_st   = st;
        lit_wrap = w;
        lit_on   = 1'b1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        cycle();
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        Step_n     = 1'b1;
        Auto_Mode  = 1'b0;
        Freeze     = 1'b0;
        Load       = 1'b0;
        Load_Value = '0;
        model_reset();
        mdl_on = 1'b1;
        cycle();
        expect_lit(5'b01111, 0, 0, 0, 0);
        cycle();
        Reset_n = 1'b1;

        // Manual press: select moves exactly 6 clocks after the fall
        Step_n = 1'b0;
        cycles(5);
        expect_lit(5'b00001, 0, 0, 0, 0);
        cycle();
        expect_lit(5'b01101, 1, 0, 0, 0);
        cycles(4);
        Step_n = 1'b1;
        cycles(8);
        // Two-clock glitch is rejected
        Step_n = 1'b0;
        cycles(2);
        Step_n = 1'b1;
        cycles(8);
        expect_lit(5'b00101, 1, 0, 0, 0);
        // Four presses from 1 come back to 1 with one wrap pulse
        wcount = 0;
        repeat (4) begin
            Step_n = 1'b0;
            cycles(5);
            Step_n = 1'b1;
            cycles(6);
        end
        lit_wc = 1;
        expect_lit(5'b10001, 1, 0, 0, 0);
        cycle();

        // Auto scan from 0
        do_reset();
        Auto_Mode = 1'b1;
        cycle();
        expect_lit(5'b00111, 0, 0, 1, 0);
        cycles(3);
        expect_lit(5'b00111, 0, 0, 1, 0);
        cycle();
        expect_lit(5'b00111, 0, 1, 2, 0);
        cycle();
        expect_lit(5'b00111, 0, 1, 2, 0);
        cycle();
        expect_lit(5'b01111, 1, 0, 1, 0);
        cycles(17);
        expect_lit(5'b01001, 3, 0, 0, 0);
        cycle();
        expect_lit(5'b01011, 0, 0, 1, 1);
        cycle();
        expect_lit(5'b01001, 0, 0, 0, 0);

        // Freeze for 10 clocks in BLANK, then finish the remaining blank count
        cycles(3);
        expect_lit(5'b00111, 0, 1, 2, 0);
        Freeze = 1'b1;
        cycles(10);
        expect_lit(5'b01111, 0, 1, 2, 0);
        Freeze = 1'b0;
        cycle();
        expect_lit(5'b00011, 0, 1, 0, 0);
        cycle();
        expect_lit(5'b00111, 1, 0, 1, 0);

        // Load beats a coincident step event; out-of-range load ignored
        Auto_Mode = 1'b0;
        cycle();
        Step_n = 1'b0;
        cycles(5);
        Load       = 1'b1;
        Load_Value = 5'd2;
        cycle();
        Load = 1'b0;
        expect_lit(5'b00101, 2, 0, 0, 0);
        Step_n = 1'b1;
        cycles(8);
        Load       = 1'b1;
        Load_Value = 5'd7;
        cycle();
        Load = 1'b0;
        expect_lit(5'b00001, 2, 0, 0, 0);
        cycle();

        // Leaving auto during BLANK at select 3
        Auto_Mode = 1'b1;
        cycle();
        Load       = 1'b1;
        Load_Value = 5'd3;
        cycle();
        Load = 1'b0;
        cycles(4);
        expect_lit(5'b00111, 3, 1, 2, 0);
        Auto_Mode = 1'b0;
        cycle();
        expect_lit(5'b00111, 3, 0, 0, 0);

        // Asynchronous reset mid-BLANK takes effect before the next edge
        Auto_Mode = 1'b1;
        cycles(5);
        expect_lit(5'b00111, 3, 1, 2, 0);
        cycle();
        Reset_n = 1'b0;
        model_reset();
        expect_lit(5'b01111, 0, 0, 0, 0);
        cycle();
        Reset_n   = 1'b1;
        Auto_Mode = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                Step_n = 1'($urandom_range(0, 1));
                hold   = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) Auto_Mode = !Auto_Mode;
            Freeze     = ($urandom_range(0, 9) == 0);
            Load       = ($urandom_range(0, 29) == 0);
            Load_Value = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle();
        end
        Freeze = 1'b0;
        Load   = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
